// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and width bounds for the bit-serial adder
package serial_adder_pkg;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: 1-bit combinational full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/busy/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             c_ff, s, co;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  fa_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(c_ff), .s(s), .co(co));
  // r_sr keeps only the upper result bits; the full word is formed when s arrives
  assign nxt = {s, r_sr};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c_ff  <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= (WIDTH-1)'(nxt >> 1);
          c_ff <= co;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= nxt;
            carry <= co;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            a_sr  <= op1;
            b_sr  <= op2;
            c_ff  <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=4
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] op1_8 = '0, op2_8 = '0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] op1_4 = '0, op2_4 = '0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;
  int         pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op1(op1_8), .op2(op2_8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );
  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op1(op1_4), .op2(op2_4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec);
    int n, nb;
    op1_8 = a; op2_8 = b; cin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    op1_8 = ~a; op2_8 = ~b;
    nb = busy8 ? 1 : 0;
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
      if (busy8) nb++;
    end
    chk("latency", n, 8);
    chk("busy_cycles", nb, 9);
    chk("sum", sum8, es);
    chk("carry", carry8, ec);
    tick();
    chk("done_width", done8, 1'b0);
    chk("idle_busy", busy8, 1'b0);
  endtask

  initial begin
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic       pc [3];
    logic [7:0] xs [3];
    logic       xc [3];
    int n, nd;
    pa = '{8'h01, 8'hF0, 8'h80};
    pb = '{8'h02, 8'h20, 8'h80};
    pc = '{1'b0, 1'b1, 1'b0};
    xs = '{8'h03, 8'h11, 8'h00};
    xc = '{1'b0, 1'b1, 1'b1};

    tick(); tick();
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_carry", carry8, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    rst_n = 1'b1;
    tick();

    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    repeat (5) tick();
    chk("sum_hold", sum8, 8'h46);
    chk("carry_hold", carry8, 1'b0);

    // start held high: accepted only at IDLE and on each DONE cycle, random ops in between
    op1_8 = pa[0]; op2_8 = pb[0]; cin8 = pc[0]; start8 = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done8 && n < 20) begin
        op1_8 = 8'($urandom); op2_8 = 8'($urandom); cin8 = 1'($urandom);
        tick();
        n++;
      end
      chk("held_latency", n, 8);
      chk("held_sum", sum8, xs[k]);
      chk("held_carry", carry8, xc[k]);
      if (k < 2) begin
        op1_8 = pa[k+1]; op2_8 = pb[k+1]; cin8 = pc[k+1];
      end else start8 = 1'b0;
      tick();
      chk("held_done_width", done8, 1'b0);
      chk("held_busy", busy8, k < 2);
    end

    // reset during RUN discards the operation
    op1_8 = 8'h0F; op2_8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    chk("mid_busy_pre", busy8, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_carry", carry8, 1'b0);
    nd = 0;
    repeat (12) begin
      tick();
      if (done8) nd++;
    end
    chk("abort_no_done", nd, 0);
    run8(8'h07, 8'h08, 1'b0, 8'h0F, 1'b0);

    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [4:0] ex;
      vv = 9'(v);
      op1_4 = vv[3:0]; op2_4 = vv[7:4]; cin4 = vv[8]; start4 = 1'b1;
      ex = {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'b0, vv[8]};
      tick();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 12) begin
        tick();
        n++;
      end
      chk("w4_sum", {carry4, sum4}, ex);
      tick();
      chk("w4_done_width", done4, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
